dp_mem_arbiter: RTL and testbench
=================================

# dp_mem_arbiter

Round-robin arbiter sharing one `dp_memory` instance between `NUM_REQ` requesters. Write and read ports are arbitrated independently, so one write and one read can be granted per cycle. Read data returns one cycle after grant on a shared data bus, with a per-requester valid strobe. The block sits directly in front of the memory and drives all of its control, address and data inputs.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; matches the memory.
- `DEPTH`, 1024: memory depth; `AW = $clog2(DEPTH)`.
- `NUM_REQ`, 4: number of requesters, 2..8.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `wreq_i` in NUM_REQ: write request, one bit per requester; held until granted.
- `waddr_i` in NUM_REQ*AW: packed write addresses; requester k occupies slice [k*AW +: AW].
- `wdata_i` in NUM_REQ*DATA_WIDTH: packed write data; requester k occupies slice [k*DATA_WIDTH +: DATA_WIDTH].
- `wgnt_o` out NUM_REQ: write grant, one-hot or zero.
- `rreq_i` in NUM_REQ: read request.
- `raddr_i` in NUM_REQ*AW: packed read addresses.
- `rgnt_o` out NUM_REQ: read grant, one-hot or zero.
- `rvalid_o` out NUM_REQ: read data valid for requester k, one-hot or zero.
- `rdata_o` out DATA_WIDTH: shared read data; meaningful only while any `rvalid_o` bit is set.
- `mem_we_o` out 1, `mem_waddr_o` out AW, `mem_wdata_o` out DATA_WIDTH: memory write port.
- `mem_re_o` out 1, `mem_raddr_o` out AW: memory read port.
- `mem_rdata_i` in DATA_WIDTH: memory registered read data.

## Operation
- Write and read arbiters are identical and independent. Each keeps a registered priority pointer `ptr` (0..NUM_REQ-1).
- Grant selection (combinational): first requesting index scanning `ptr, ptr+1, ..., ptr+NUM_REQ-1` modulo NUM_REQ. No request means no grant.
- Transfer occurs in any cycle where `req[k] & gnt[k]`. After a transfer to k, `ptr <= (k+1) mod NUM_REQ`. With no grant, `ptr` holds.
- Write port: `mem_we_o = |wgnt_o`. `mem_waddr_o` and `mem_wdata_o` are muxed from the granted slice, and are 0 when there is no grant.
- Read port: `mem_re_o = |rgnt_o`. `mem_raddr_o` is muxed from the granted slice, and is 0 when there is no grant.
- Read return: a registered `rsel` (NUM_REQ bits) captures `rgnt_o`. In the next cycle `rvalid_o = rsel` and `rdata_o = mem_rdata_i` (passed through, not re-registered).
- Requesters must hold `req`, `addr` and `data` stable until granted. Dropping `req` before grant is legal and cancels the request.
- Write and read to the same address in the same cycle: no forwarding. Read returns the pre-write word, per memory semantics.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles on each port.
- Reset (`rst_i` high):
  - `ptr` = 0 on both ports and `rsel` = 0.
  - All grants are forced to 0, `mem_we_o` = `mem_re_o` = 0, and `rvalid_o` = 0 in every cycle `rst_i` is high.
  - A read granted in the cycle before reset asserts does not return `rvalid` while in reset. After reset releases, `rvalid_o` stays 0 until a new read grant.

## Timing
- Grant: same cycle as request, combinational from `req` and `ptr`.
- Write latency: memory updated at the clock edge ending the grant cycle.
- Read latency: `rvalid_o[k]` and `rdata_o` are valid exactly 1 cycle after the `rgnt_o[k]` cycle.
- Throughput: 1 write plus 1 read per cycle, back-to-back, with no idle cycles between grants.
- `ptr` and `rsel` update on `posedge clk_i` only. No combinational path from `mem_rdata_i` to any grant.

## Test plan
- Reset: hold `rst_i` 3 cycles with all `wreq_i` and `rreq_i` = 1 -> `wgnt_o` = `rgnt_o` = `rvalid_o` = 0 and `mem_we_o` = `mem_re_o` = 0. In the first cycle after release, requester 0 is granted on both ports.
- Round-robin: NUM_REQ=4, `wreq_i` = 4'b1111 held for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3. Then with `wreq_i` = 4'b1010 -> grants alternate 1,3,1,3.
- Write then read: requester 2 writes 0xDEADBEEF to address 0x05. Next cycle requester 1 reads 0x05 -> `rvalid_o` = 4'b0010 and `rdata_o` = 0xDEADBEEF one cycle after `rgnt_o[1]`.
- Same-cycle collision: address 0x10 holds 0x1; write 0x2 and read 0x10 in the same cycle -> read returns 0x1; a following read returns 0x2.
- Concurrent ports: requester 0 writes while requester 3 reads in the same cycle -> both granted, `mem_we_o` = `mem_re_o` = 1, and `rvalid_o[3]` asserts the next cycle.
- Reset mid-read: `rgnt_o[2]` in cycle N and `rst_i` high in cycle N+1 -> `rvalid_o` = 0 in N+1 and stays 0 until a new read grant.

Source files
------------

// File: rtl/dp_mem_arbiter.sv
// Round-robin arbiter sharing one dual-port memory between NUM_REQ requesters.
// Write and read ports are arbitrated independently; reads return one cycle after grant.
module dp_mem_arbiter_rr #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Grant the first requester scanning from ptr upward, wrapping modulo N.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
            end
        end
        if (rst_i) begin
            gnt_o = '0;
            ptr_d = ptr_q;
        end
    end

    // Priority pointer moves past the most recent winner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

module dp_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int NUM_REQ    = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            wreq_i,
    input  logic [NUM_REQ*AW-1:0]         waddr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            wgnt_o,
    input  logic [NUM_REQ-1:0]            rreq_i,
    input  logic [NUM_REQ*AW-1:0]         raddr_i,
    output logic [NUM_REQ-1:0]            rgnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          mem_we_o,
    output logic [AW-1:0]                 mem_waddr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic                          mem_re_o,
    output logic [AW-1:0]                 mem_raddr_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);
    logic [NUM_REQ-1:0] rsel_q;

    dp_mem_arbiter_rr #(.N(NUM_REQ)) u_warb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (wreq_i),
        .gnt_o (wgnt_o)
    );

    dp_mem_arbiter_rr #(.N(NUM_REQ)) u_rarb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (rreq_i),
        .gnt_o (rgnt_o)
    );

    // Steer the granted requester's slices onto the memory ports; zero when idle.
    always_comb begin
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        mem_raddr_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (wgnt_o[k]) begin
                mem_waddr_o = waddr_i[k*AW +: AW];
                mem_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rgnt_o[k]) begin
                mem_raddr_o = raddr_i[k*AW +: AW];
            end
        end
    end

    assign mem_we_o = |wgnt_o;
    assign mem_re_o = |rgnt_o;

    // Remember which requester owns the read data arriving next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsel_q <= '0;
        end else begin
            rsel_q <= rgnt_o;
        end
    end

    // Suppress a return still in flight when reset lands on top of it.
    assign rvalid_o = rst_i ? '0 : rsel_q;
    assign rdata_o  = mem_rdata_i;
endmodule

// File: tb/tb_dp_mem_arbiter.sv
// Directed bench for dp_mem_arbiter with a behavioural registered-read memory.
module tb_dp_mem_arbiter;
    localparam int DW = 32;
    localparam int DEPTH = 1024;
    localparam int NR = 4;
    localparam int AW = 10;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     wreq;
    logic [NR*AW-1:0]  waddr;
    logic [NR*DW-1:0]  wdata;
    logic [NR-1:0]     wgnt;
    logic [NR-1:0]     rreq;
    logic [NR*AW-1:0]  raddr;
    logic [NR-1:0]     rgnt;
    logic [NR-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_re;
    logic [AW-1:0]     mem_raddr;
    logic [DW-1:0]     mem_rdata;

    logic [DW-1:0]     mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    dp_mem_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wreq_i      (wreq),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .wgnt_o      (wgnt),
        .rreq_i      (rreq),
        .raddr_i     (raddr),
        .rgnt_o      (rgnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .mem_we_o    (mem_we),
        .mem_waddr_o (mem_waddr),
        .mem_wdata_o (mem_wdata),
        .mem_re_o    (mem_re),
        .mem_raddr_o (mem_raddr),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory: a same-edge read sees the old word.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wreq = '0;
        rreq = '0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wreq = '1;
        rreq = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wgnt !== 4'b0 || rgnt !== 4'b0) begin
                $display("FAIL reset_gnt cyc %0d got w=%b r=%b exp 0", c, wgnt, rgnt);
                n_err++;
            end
            n_cmp++;
            if (rvalid !== 4'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
                $display("FAIL reset_strobes cyc %0d got rv=%b we=%b re=%b exp 0",
                         c, rvalid, mem_we, mem_re);
                n_err++;
            end
            n_cmp++;
            next_cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        if (wgnt !== 4'b0001 || rgnt !== 4'b0001) begin
            $display("FAIL reset_release got w=%b r=%b exp 0001", wgnt, rgnt);
            n_err++;
        end
        n_cmp++;
        if (rvalid !== 4'b0) begin
            $display("FAIL reset_release_rvalid got %b exp 0", rvalid);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp;
        do_reset();
        wreq = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            waddr[k*AW +: AW] = AW'(10'h100 + k);
            wdata[k*DW +: DW] = 32'hA000_0000 + k;
        end
        for (int c = 0; c < 8; c++) begin
            exp = 4'b0001 << (c % 4);
            @(negedge clk);
            if (wgnt !== exp || mem_we !== 1'b1) begin
                $display("FAIL rr_all cyc %0d got %b we=%b exp %b we=1", c, wgnt, mem_we, exp);
                n_err++;
            end
            n_cmp++;
            if (mem_waddr !== AW'(10'h100 + (c % 4))) begin
                $display("FAIL rr_addr cyc %0d got %h exp %h", c, mem_waddr, 10'h100 + (c % 4));
                n_err++;
            end
            n_cmp++;
            next_cyc();
        end
        wreq = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            exp = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            @(negedge clk);
            if (wgnt !== exp) begin
                $display("FAIL rr_1010 cyc %0d got %b exp %b", c, wgnt, exp);
                n_err++;
            end
            n_cmp++;
            next_cyc();
        end
        wreq = '0;
        @(negedge clk);
        if (wgnt !== 4'b0 || mem_we !== 1'b0 || mem_waddr !== '0 || mem_wdata !== '0) begin
            $display("FAIL rr_idle got g=%b we=%b a=%h d=%h exp all 0",
                     wgnt, mem_we, mem_waddr, mem_wdata);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        wreq[2] = 1'b1;
        waddr[2*AW +: AW] = 10'h005;
        wdata[2*DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        if (wgnt !== 4'b0100 || mem_we !== 1'b1 || mem_waddr !== 10'h005
            || mem_wdata !== 32'hDEAD_BEEF) begin
            $display("FAIL wr_grant got g=%b we=%b a=%h d=%h exp 0100 1 005 deadbeef",
                     wgnt, mem_we, mem_waddr, mem_wdata);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        idle_inputs();
        rreq[1] = 1'b1;
        raddr[1*AW +: AW] = 10'h005;
        @(negedge clk);
        if (rgnt !== 4'b0010 || mem_re !== 1'b1 || mem_raddr !== 10'h005) begin
            $display("FAIL rd_grant got g=%b re=%b a=%h exp 0010 1 005", rgnt, mem_re, mem_raddr);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        idle_inputs();
        @(negedge clk);
        if (rvalid !== 4'b0010 || rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL rd_return got v=%b d=%h exp 0010 deadbeef", rvalid, rdata);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        @(negedge clk);
        if (rvalid !== 4'b0) begin
            $display("FAIL rd_return_clear got %b exp 0", rvalid);
            n_err++;
        end
        n_cmp++;
        next_cyc();
    endtask

    task automatic test_collision();
        do_reset();
        wreq[0] = 1'b1;
        waddr[0 +: AW] = 10'h010;
        wdata[0 +: DW] = 32'h1;
        next_cyc();
        wdata[0 +: DW] = 32'h2;
        rreq[0] = 1'b1;
        raddr[0 +: AW] = 10'h010;
        @(negedge clk);
        if (wgnt !== 4'b0001 || rgnt !== 4'b0001) begin
            $display("FAIL coll_grant got w=%b r=%b exp 0001 0001", wgnt, rgnt);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        wreq = '0;
        @(negedge clk);
        if (rvalid !== 4'b0001 || rdata !== 32'h1) begin
            $display("FAIL coll_old got v=%b d=%h exp 0001 1", rvalid, rdata);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        rreq = '0;
        @(negedge clk);
        if (rvalid !== 4'b0001 || rdata !== 32'h2) begin
            $display("FAIL coll_new got v=%b d=%h exp 0001 2", rvalid, rdata);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_concurrent();
        do_reset();
        wreq[0] = 1'b1;
        waddr[0 +: AW] = 10'h020;
        wdata[0 +: DW] = 32'h5555_AAAA;
        rreq[3] = 1'b1;
        raddr[3*AW +: AW] = 10'h010;
        @(negedge clk);
        if (wgnt !== 4'b0001 || rgnt !== 4'b1000 || mem_we !== 1'b1 || mem_re !== 1'b1
            || mem_raddr !== 10'h010) begin
            $display("FAIL conc_grant got w=%b r=%b we=%b re=%b ra=%h exp 0001 1000 1 1 010",
                     wgnt, rgnt, mem_we, mem_re, mem_raddr);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        idle_inputs();
        @(negedge clk);
        if (rvalid !== 4'b1000 || rdata !== 32'h2) begin
            $display("FAIL conc_return got v=%b d=%h exp 1000 2", rvalid, rdata);
            n_err++;
        end
        n_cmp++;
        next_cyc();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        rreq[2] = 1'b1;
        raddr[2*AW +: AW] = 10'h005;
        @(negedge clk);
        if (rgnt !== 4'b0100) begin
            $display("FAIL rmr_grant got %b exp 0100", rgnt);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        rreq = '0;
        rst = 1'b1;
        @(negedge clk);
        if (rvalid !== 4'b0 || rgnt !== 4'b0) begin
            $display("FAIL rmr_in_reset got v=%b g=%b exp 0 0", rvalid, rgnt);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rvalid !== 4'b0) begin
                $display("FAIL rmr_after cyc %0d got %b exp 0", c, rvalid);
                n_err++;
            end
            n_cmp++;
            next_cyc();
        end
        rreq[2] = 1'b1;
        next_cyc();
        rreq = '0;
        @(negedge clk);
        if (rvalid !== 4'b0100 || rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL rmr_new_read got v=%b d=%h exp 0100 deadbeef", rvalid, rdata);
            n_err++;
        end
        n_cmp++;
        next_cyc();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_round_robin();
        test_write_read();
        test_collision();
        test_concurrent();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
